// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the main-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_A_WIDTH    = 13;
    localparam int unsigned MEM_D_WIDTH    = 16;
    localparam int unsigned MEM_MASK_WIDTH = 2;

    // One requester's access, as presented to the memory port.
    typedef struct packed {
        logic [MEM_A_WIDTH-1:0]    addr;
        logic                      we;
        logic [MEM_MASK_WIDTH-1:0] mask;
        logic [MEM_D_WIDTH-1:0]    wdata;
        logic                      lock;
    } mem_req_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first set bit of req at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic found;

    // Walk offsets from ptr; the first requesting slot wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (32'(ptr) + off) % N)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port, with a timed RMW lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned LOCK_TIMEOUT = 15
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0][MEM_A_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]                     req_we,
    input  logic [NUM_REQ-1:0][MEM_MASK_WIDTH-1:0] req_mask,
    input  logic [NUM_REQ-1:0][MEM_D_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ-1:0]                     req_lock,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [MEM_D_WIDTH-1:0]                 rsp_rdata,
    output logic                                   lock_abort,
    output logic [MEM_A_WIDTH-1:0]                 mem_addr,
    output logic                                   mem_write_en,
    output logic [MEM_MASK_WIDTH-1:0]              mem_write_mask,
    output logic [MEM_D_WIDTH-1:0]                 mem_write_data,
    input  logic [MEM_D_WIDTH-1:0]                 mem_read_data
);

    localparam int unsigned     PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned     CntW    = 8;
    localparam logic [CntW-1:0] CntMax  = CntW'(LOCK_TIMEOUT);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

    lock_state_t        state_q, state_d;
    logic [PtrW-1:0]    owner_q, owner_d;
    logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic [NUM_REQ-1:0] owner_oh, cand, pick, grant;
    logic [PtrW-1:0]    grant_idx;
    logic               granted, owner_valid, abort;
    mem_req_t           sel;

    function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    // Candidates: everyone when unlocked, only the owner while a lock is held.
    always_comb begin
        owner_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == PtrW'(i));
        end
        owner_valid = |(req_valid & owner_oh);
        cand        = (state_q == LOCKED) ? (req_valid & owner_oh) : req_valid;
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PtrW)
    ) u_rr_pick (
        .req   (cand),
        .ptr   (rr_ptr_q),
        .grant (pick)
    );

    // Select the granted access; grant is forced low while reset is asserted.
    always_comb begin
        grant     = rst_n ? pick : '0;
        granted   = |grant;
        grant_idx = '0;
        sel       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PtrW'(i);
                sel.addr  = req_addr[i];
                sel.we    = req_we[i];
                sel.mask  = req_mask[i];
                sel.wdata = req_wdata[i];
                sel.lock  = req_lock[i];
            end
        end
        // An idle owner at the count limit loses the lock; nobody is granted this cycle.
        abort = rst_n && (state_q == LOCKED) && !owner_valid && (lock_cnt_q == CntMax);
    end

    // Lock FSM, round-robin pointer and lock hold counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (granted) begin
            rr_ptr_d   = next_idx(grant_idx);
            lock_cnt_d = '0;
            if (sel.lock) begin
                state_d = LOCKED;
                owner_d = grant_idx;
            end else begin
                state_d = UNLOCKED;
            end
        end else if (state_q == LOCKED) begin
            if (abort) begin
                state_d    = UNLOCKED;
                rr_ptr_d   = next_idx(owner_q);
                lock_cnt_d = '0;
            end else if (lock_cnt_q < CntMax) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    // State registers; the response strobe records last cycle's grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= grant;
        end
    end

    assign req_ready      = grant;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = mem_read_data;
    assign lock_abort     = abort;
    assign mem_addr       = sel.addr;
    assign mem_write_en   = sel.we;
    assign mem_write_mask = sel.mask;
    assign mem_write_data = sel.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;

    localparam int NR = 3;
    localparam int TO = 15;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [NR-1:0]       req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [NR-1:0][12:0] req_addr;
    logic [NR-1:0][1:0]  req_mask;
    logic [NR-1:0][15:0] req_wdata;
    logic [15:0]         rsp_rdata, mem_write_data, mem_read_data;
    logic                lock_abort, mem_write_en;
    logic [12:0]         mem_addr;
    logic [1:0]          mem_write_mask;

    mem_port_arbiter #(
        .NUM_REQ        (NR),
        .LOCK_TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_we         (req_we),
        .req_mask       (req_mask),
        .req_wdata      (req_wdata),
        .req_lock       (req_lock),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .lock_abort     (lock_abort),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_mask (mem_write_mask),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory: 1-cycle synchronous read (old data), byte-masked write.
    logic [15:0] env_mem [8192];
    initial begin
        for (int i = 0; i < 8192; i++) env_mem[i] <= 16'h0000;
    end
    always @(posedge clk) begin
        mem_read_data <= env_mem[mem_addr];
        if (mem_write_en) begin
            if (mem_write_mask[0]) env_mem[mem_addr][7:0]  <= mem_write_data[7:0];
            if (mem_write_mask[1]) env_mem[mem_addr][15:8] <= mem_write_data[15:8];
        end
    end

    // Reference model state
    logic [15:0] m_mem [8192];
    int          m_rr, m_owner, m_cnt, m_prev;
    bit          m_locked, m_prev_rd;
    logic [15:0] m_prev_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    int          obs_idx;
    logic [NR-1:0] obs_ready;
    logic [15:0] obs_rdata;
    logic        obs_abort;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has(input logic [NR-1:0] v, input int i);
        return (v & (NR'(1) << i)) != '0;
    endfunction

    // One clock cycle: check DUT outputs against the model at the negedge, advance the model.
    task automatic tick();
        int          g;
        bit          ab, we, lk;
        logic [12:0] a;
        logic [1:0]  mk;
        logic [15:0] d, rd;
        logic [NR-1:0] exp_ready;
        @(negedge clk);
        g  = -1;
        ab = 1'b0;
        if (!m_locked) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && has(req_valid, (m_rr + k) % NR)) g = (m_rr + k) % NR;
            end
        end else if (has(req_valid, m_owner)) begin
            g = m_owner;
        end else if (m_cnt == TO) begin
            ab = 1'b1;
        end
        a = '0; mk = '0; d = '0; we = 1'b0; lk = 1'b0; exp_ready = '0;
        if (g >= 0) begin
            a  = req_addr[IW'(g)];
            mk = req_mask[IW'(g)];
            d  = req_wdata[IW'(g)];
            we = req_we[IW'(g)];
            lk = req_lock[IW'(g)];
            exp_ready = NR'(1) << g;
        end
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("lock_abort", 32'(lock_abort), 32'(ab));
        check_eq("mem_write_en", 32'(mem_write_en), 32'(we));
        check_eq("mem_addr", 32'(mem_addr), 32'(a));
        check_eq("mem_write_mask", 32'(mem_write_mask), 32'(mk));
        check_eq("mem_write_data", 32'(mem_write_data), 32'(d));
        check_eq("rsp_valid", 32'(rsp_valid), (m_prev >= 0) ? (32'd1 << m_prev) : 32'd0);
        if (m_prev >= 0 && m_prev_rd) check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_prev_rdata));
        obs_ready = req_ready;
        obs_rdata = rsp_rdata;
        obs_abort = lock_abort;
        obs_idx   = -1;
        for (int i = NR - 1; i >= 0; i--) if (has(req_ready, i)) obs_idx = i;
        // Model update
        rd = m_mem[a];
        if (g >= 0) begin
            if (we) begin
                if (mk[0]) m_mem[a][7:0]  = d[7:0];
                if (mk[1]) m_mem[a][15:8] = d[15:8];
            end
            m_rr     = (g + 1) % NR;
            m_locked = lk;
            if (lk) m_owner = g;
            m_cnt    = 0;
        end else if (m_locked) begin
            if (ab) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % NR;
                m_cnt    = 0;
            end else begin
                m_cnt++;
            end
        end
        m_prev       = g;
        m_prev_rd    = (g >= 0) && !we;
        m_prev_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_mask = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input logic [12:0] a,
                           input logic [1:0] mk, input logic [15:0] d, input bit lk);
        req_valid[IW'(i)] = v;
        req_we[IW'(i)]    = we;
        req_addr[IW'(i)]  = a;
        req_mask[IW'(i)]  = mk;
        req_wdata[IW'(i)] = d;
        req_lock[IW'(i)]  = lk;
    endtask

    // Asynchronous reset: outputs must clear at once, even with requests pending.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_lock_abort", 32'(lock_abort), 32'd0);
        check_eq("rst_mem_we", 32'(mem_write_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_mask", 32'(mem_write_mask), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_write_data), 32'd0);
        clr();
        m_rr = 0; m_owner = 0; m_cnt = 0; m_prev = -1;
        m_locked = 1'b0; m_prev_rd = 1'b0;
        obs_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dens;
        for (int i = 0; i < 8192; i++) m_mem[i] = 16'h0000;
        clr();
        #1;
        do_reset();

        // Single requester write then read-back
        set_req(0, 1, 1, 13'h0005, 2'b11, 16'hBEEF, 0);
        tick(); check_eq("t1_grant_wr", 32'(obs_idx), 32'd0);
        set_req(0, 1, 0, 13'h0005, 2'b00, 16'h0000, 0);
        tick(); check_eq("t1_grant_rd", 32'(obs_idx), 32'd0);
        clr();
        tick(); check_eq("t1_rdata", 32'(obs_rdata), 32'hBEEF);

        // Round-robin order from reset
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1, 0, 13'(i + 1), 2'b00, 16'h0, 0);
        for (int k = 0; k < 6; k++) begin
            tick(); check_eq("t2_rr_order", 32'(obs_idx), 32'(k % NR));
        end
        clr(); tick();

        // Byte-mask merge
        set_req(0, 1, 1, 13'h0010, 2'b11, 16'h1234, 0); tick();
        set_req(0, 1, 1, 13'h0010, 2'b10, 16'hAB00, 0); tick();
        set_req(0, 1, 0, 13'h0010, 2'b00, 16'h0000, 0); tick();
        clr();
        tick(); check_eq("t3_mask_rdata", 32'(obs_rdata), 32'hAB34);

        // Lock excludes others until released
        set_req(1, 1, 0, 13'h1FFF, 2'b00, 16'h0, 1);
        tick(); check_eq("t4_lock_grant", 32'(obs_idx), 32'd1);
        set_req(0, 1, 0, 13'h0020, 2'b00, 16'h0, 0);
        set_req(2, 1, 0, 13'h0021, 2'b00, 16'h0, 0);
        set_req(1, 1, 1, 13'h1FFF, 2'b11, 16'h5A5A, 0);
        tick(); check_eq("t4_owner_only", 32'(obs_idx), 32'd1);
        set_req(1, 0, 0, 13'h0, 2'b00, 16'h0, 0);
        tick(); check_eq("t4_after_rel", 32'(obs_idx), 32'd2);
        set_req(2, 0, 0, 13'h0, 2'b00, 16'h0, 0);
        tick(); check_eq("t4_then_req0", 32'(obs_idx), 32'd0);
        clr(); tick();

        // Lock timeout
        set_req(2, 1, 0, 13'h0030, 2'b00, 16'h0, 1);
        tick(); check_eq("t5_lock_grant", 32'(obs_idx), 32'd2);
        clr();
        set_req(0, 1, 0, 13'h0031, 2'b00, 16'h0, 0);
        for (int k = 1; k <= TO + 2; k++) begin
            tick();
            check_eq("t5_abort_pulse", 32'(obs_abort), 32'(k == TO + 1));
            if (k <= TO + 1) check_eq("t5_no_grant", 32'(obs_ready), 32'd0);
            else             check_eq("t5_req0_after", 32'(obs_idx), 32'd0);
        end
        clr(); tick();

        // Reset while req1 holds the lock with a read in flight
        set_req(1, 1, 0, 13'h0100, 2'b00, 16'h0, 1);
        tick(); check_eq("t6_lock_grant", 32'(obs_idx), 32'd1);
        set_req(0, 1, 0, 13'h0101, 2'b00, 16'h0, 0);
        set_req(1, 1, 0, 13'h0100, 2'b00, 16'h0, 1);
        do_reset();
        set_req(0, 1, 0, 13'h0101, 2'b00, 16'h0, 0);
        set_req(1, 1, 0, 13'h0100, 2'b00, 16'h0, 1);
        tick(); check_eq("t6_first_after_rst", 32'(obs_idx), 32'd0);

        // Randomized traffic; stalled requesters hold their request
        dens = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) dens = $urandom_range(1, 7);
            for (int i = 0; i < NR; i++) begin
                if (!(has(req_valid, i) && !has(obs_ready, i))) begin
                    set_req(i, $urandom_range(0, 7) < dens, 1'($urandom),
                            ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7)),
                            2'($urandom), 16'($urandom), $urandom_range(0, 5) == 0);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
